// File: rtl/mod_add_pipe.sv
// Two-stage pipelined modular adder c = (a + b) mod q with valid/ready flow control,
// a block-end tag carried per element, and a count of results handed off.
module mod_add_pipe #(
    parameter int W     = 23,
    parameter int CNT_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     q_i,
    input  logic             last_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [W-1:0]     c_o,
    output logic             last_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic           s1_valid;
    logic [W:0]     s1_sum;
    logic [W-1:0]   s1_q;
    logic           s1_last;
    logic           s2_valid;
    logic           adv1;
    logic           adv2;
    logic           sum_ge_q;
    logic [W-1:0]   diff;
    logic [W-1:0]   c_next;

    // A stage may load when it is empty or its contents move on this edge.
    assign adv2    = !s2_valid || ready_i;
    assign adv1    = !s1_valid || adv2;
    assign ready_o = adv1;
    assign valid_o = s2_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_q     <= '0;
            s1_last  <= 1'b0;
        end else if (adv1) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_sum  <= {1'b0, a_i} + {1'b0, b_i};
                s1_q    <= q_i;
                s1_last <= last_i;
            end
        end
    end

    // Low W bits of the full-width difference equal the W-bit difference.
    always_comb begin
        sum_ge_q = (s1_sum >= {1'b0, s1_q});
        diff     = s1_sum[W-1:0] - s1_q;
        c_next   = sum_ge_q ? diff : s1_sum[W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            c_o      <= '0;
            last_o   <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                c_o    <= c_next;
                last_o <= s1_last;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (s2_valid && ready_i) begin
            cnt_o <= last_o ? '0 : cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mod_add_pipe.sv
// Self-checking bench for mod_add_pipe: directed scenarios plus a randomized
// scoreboard run against an arithmetic reference model.
module tb_mod_add_pipe;

    localparam int W     = 23;
    localparam int CNT_W = 9;
    localparam logic [W-1:0] QD = 23'h7FE001;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [W-1:0]     a_i = '0, b_i = '0, q_i = '0;
    logic             last_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic             ready_o, last_o, valid_o;
    logic [W-1:0]     c_o;
    logic [CNT_W-1:0] cnt_o;

    mod_add_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .a_i(a_i), .b_i(b_i), .q_i(q_i),
        .last_i(last_i), .valid_i(valid_i), .ready_o(ready_o), .c_o(c_o),
        .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i), .cnt_o(cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    // reference model state
    logic [W-1:0] q_c[$];
    logic         q_l[$];
    int           mcnt = 0;

    // per-cycle observations
    logic         in_x, out_x, have_exp;
    logic [W-1:0] exp_c, obs_c = '0, c_prev;
    logic         exp_l, obs_l = 1'b0, l_prev;
    logic         obs_v = 1'b0, obs_rdy, stall_prev;

    function automatic logic [W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] q);
        longint s;
        s = longint'(a) + longint'(b);
        if (s >= longint'(q)) s = s - longint'(q);
        return W'(s % (longint'(1) << W));
    endfunction

    // Drives one cycle, records what the DUT showed, and keeps the model in step.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic l, input logic r);
        @(negedge clk_i);
        stall_prev = obs_v && !ready_i;
        c_prev = obs_c;
        l_prev = obs_l;
        valid_i = v; a_i = a; b_i = b; q_i = q; last_i = l; ready_i = r;
        #1;
        in_x = valid_i && ready_o;
        out_x = valid_o && ready_i;
        obs_c = c_o; obs_l = last_o; obs_v = valid_o; obs_rdy = ready_o;
        have_exp = 1'b0;
        if (out_x && q_c.size() > 0) begin
            exp_c = q_c.pop_front();
            exp_l = q_l.pop_front();
            have_exp = 1'b1;
        end
        if (in_x) begin
            q_c.push_back(golden(a, b, q));
            q_l.push_back(l);
        end
        @(posedge clk_i);
        #1;
        if (out_x && have_exp) mcnt = exp_l ? 0 : (mcnt + 1) % (1 << CNT_W);
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = 1'b0;
        rst_i = 1'b1;
        q_c.delete(); q_l.delete();
        mcnt = 0; obs_v = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        total++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passed++;
        total++; if (c_o !== '0) $display("FAIL reset_c: got %0d want 0", c_o); else passed++;
        total++; if (last_o !== 1'b0) $display("FAIL reset_last: got %b want 0", last_o); else passed++;
        total++; if (cnt_o !== '0) $display("FAIL reset_cnt: got %0d want 0", cnt_o); else passed++;
        total++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else passed++;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        step(1'b1, 23'd5, 23'd7, QD, 1'b0, 1'b1);
        total++; if (in_x !== 1'b1) $display("FAIL basic_accept: got %b want 1", in_x); else passed++;
        step(1'b0, '0, '0, QD, 1'b0, 1'b1);
        total++; if (obs_v !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", obs_v); else passed++;
        step(1'b0, '0, '0, QD, 1'b0, 1'b1);
        total++; if (obs_v !== 1'b1) $display("FAIL basic_latency_valid: got %b want 1", obs_v); else passed++;
        total++; if (obs_c !== 23'd12) $display("FAIL basic_sum: got %0d want 12", obs_c); else passed++;
        total++; if (cnt_o !== CNT_W'(1)) $display("FAIL basic_cnt: got %0d want 1", cnt_o); else passed++;
    endtask

    task automatic test_boundary();
        logic [W-1:0] lit[2];
        int n;
        lit[0] = 23'd0;
        lit[1] = 23'd8380415;
        n = 0;
        step(1'b1, 23'd8380416, 23'd1, QD, 1'b0, 1'b1);
        step(1'b1, 23'd8380416, 23'd8380416, QD, 1'b0, 1'b1);
        for (int i = 0; i < 10 && n < 2; i++) begin
            step(1'b0, '0, '0, QD, 1'b0, 1'b1);
            if (out_x) begin
                total++;
                if (obs_c !== lit[n]) $display("FAIL boundary_%0d: got %0d want %0d", n, obs_c, lit[n]);
                else passed++;
                n++;
            end
        end
        total++; if (n != 2) $display("FAIL boundary_count: got %0d want 2", n); else passed++;
    endtask

    task automatic test_stall();
        int sent, got;
        logic saw_low;
        sent = 0; got = 0; saw_low = 1'b0;
        for (int i = 0; i < 40 && got < 8; i++) begin
            step(sent < 8, W'(sent), 23'd1, QD, 1'b0, !(i >= 3 && i <= 5));
            if (in_x) sent++;
            if (i >= 3 && i <= 5) begin
                total++;
                if (obs_rdy !== 1'b0) $display("FAIL stall_ready_%0d: got %b want 0", i, obs_rdy); else passed++;
                saw_low = 1'b1;
            end
            if (stall_prev) begin
                total++;
                if (obs_v !== 1'b1 || obs_c !== c_prev)
                    $display("FAIL stall_hold_%0d: got v=%b c=%0d want v=1 c=%0d", i, obs_v, obs_c, c_prev);
                else passed++;
            end
            if (out_x) begin
                total++;
                if (obs_c !== W'(got + 1)) $display("FAIL stall_out_%0d: got %0d want %0d", got, obs_c, got + 1);
                else passed++;
                got++;
            end
        end
        total++; if (got != 8 || !saw_low) $display("FAIL stall_count: got %0d want 8", got); else passed++;
        total++; if (q_c.size() != 0) $display("FAIL stall_leftover: got %0d want 0", q_c.size()); else passed++;
    endtask

    task automatic test_block();
        int sent, got, max_cnt, errs;
        logic final_last;
        logic [W-1:0] a, b;
        apply_reset();
        sent = 0; got = 0; max_cnt = 0; errs = 0; final_last = 1'b0;
        for (int i = 0; i < 400 && got < 256; i++) begin
            a = W'($urandom_range(8380416, 0));
            b = W'($urandom_range(8380416, 0));
            step(sent < 256, a, b, QD, sent == 255, 1'b1);
            if (in_x) sent++;
            if (out_x) begin
                got++;
                if (!have_exp || obs_c !== exp_c) errs++;
                if (got == 256) final_last = obs_l;
            end
            if (int'(cnt_o) > max_cnt) max_cnt = int'(cnt_o);
        end
        total++; if (errs != 0) $display("FAIL block_data: got %0d bad want 0", errs); else passed++;
        total++; if (max_cnt != 255) $display("FAIL block_cnt_peak: got %0d want 255", max_cnt); else passed++;
        total++; if (final_last !== 1'b1) $display("FAIL block_last: got %b want 1", final_last); else passed++;
        total++; if (cnt_o !== '0) $display("FAIL block_cnt_clear: got %0d want 0", cnt_o); else passed++;
    endtask

    task automatic test_reset_mid();
        int got;
        step(1'b1, 23'd10, 23'd20, QD, 1'b0, 1'b1);
        step(1'b1, 23'd11, 23'd21, QD, 1'b0, 1'b1);
        step(1'b1, 23'd12, 23'd22, QD, 1'b0, 1'b1);
        total++; if (int'(cnt_o) != mcnt || cnt_o == '0) $display("FAIL rstmid_pre_cnt: got %0d want %0d", cnt_o, mcnt); else passed++;
        @(negedge clk_i);
        valid_i = 1'b0; ready_i = 1'b1;
        rst_i = 1'b1;
        #1;
        total++; if (valid_o !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", valid_o); else passed++;
        total++; if (cnt_o !== '0) $display("FAIL rstmid_cnt: got %0d want 0", cnt_o); else passed++;
        q_c.delete(); q_l.delete(); mcnt = 0; obs_v = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        got = 0;
        step(1'b1, 23'd4000000, 23'd4380417, QD, 1'b0, 1'b1);
        for (int i = 0; i < 10 && got < 1; i++) begin
            step(1'b0, '0, '0, QD, 1'b0, 1'b1);
            if (out_x) begin
                total++;
                if (obs_c !== 23'd0) $display("FAIL rstmid_first: got %0d want 0", obs_c); else passed++;
                got++;
            end
        end
        total++; if (got != 1) $display("FAIL rstmid_count: got %0d want 1", got); else passed++;
    endtask

    task automatic test_random();
        localparam int N = 10000;
        int sent, got;
        logic [W-1:0] a, b, q;
        sent = 0; got = 0;
        for (int i = 0; i < 8 * N && got < N; i++) begin
            q = W'($urandom_range((1 << W) - 1, 1));
            a = W'($urandom);
            b = W'($urandom);
            step((sent < N) && ($urandom_range(3, 0) != 0), a, b, q,
                 $urandom_range(15, 0) == 0, $urandom_range(9, 0) < 7);
            if (in_x) sent++;
            if (stall_prev) begin
                total++;
                if (obs_v !== 1'b1 || obs_c !== c_prev || obs_l !== l_prev)
                    $display("FAIL rand_hold_%0d: got v=%b c=%0d l=%b want v=1 c=%0d l=%b",
                             i, obs_v, obs_c, obs_l, c_prev, l_prev);
                else passed++;
            end
            if (out_x) begin
                total++;
                if (!have_exp || obs_c !== exp_c || obs_l !== exp_l)
                    $display("FAIL rand_out_%0d: got c=%0d l=%b want c=%0d l=%b", got, obs_c, obs_l, exp_c, exp_l);
                else passed++;
                got++;
                total++;
                if (int'(cnt_o) != mcnt) $display("FAIL rand_cnt_%0d: got %0d want %0d", got, cnt_o, mcnt);
                else passed++;
            end
        end
        total++; if (got != N) $display("FAIL rand_count: got %0d want %0d", got, N); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_stall();
        test_block();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
